uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. Each received byte is captured on the receiver's one-cycle data-ready pulse, together with its parity-error flag. Bytes are presented first-word-fall-through to the consumer (CPU/bus bridge) through a valid/ready handshake. The block also reports level, threshold and overflow status, plus a receive-idle timeout, for interrupt generation.

## Interface
Parameters:
- DEPTH, 16 — entry count; power of two, ≥ 2.
- THRESH, 8 — level at or above which `thr` asserts; 1..DEPTH.
- TIMEOUT_TICKS, 80 — brclk_x2 ticks of inactivity before `timeout` asserts while non-empty; ≥ 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- brclk_x2  in  1  baud tick, one-cycle pulse (same tick the receiver uses).
- rx_data  in  8  received byte.
- rx_perr  in  1  parity error for rx_data.
- rx_ready  in  1  one-cycle strobe: rx_data/rx_perr valid this cycle.
- rd_data  out  8  head-of-queue byte.
- rd_perr  out  1  parity flag stored with head byte.
- rd_valid  out  1  head entry present (= !empty).
- rd_ready  in  1  consumer accepts head this cycle.
- count  out  $clog2(DEPTH)+1  current fill level.
- empty / full  out  1  count==0 / count==DEPTH.
- thr  out  1  count ≥ THRESH.
- overflow  out  1  sticky: a byte was dropped.
- ovf_clr  in  1  clears overflow.
- timeout  out  1  idle timeout level.

## Operation
- Storage: DEPTH × 9 bits {perr, data}. Write pointer `wp`, read pointer `rp` are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is held in a separate register.
- Push = rx_ready. Pop = rd_valid && rd_ready. rd_ready while empty is ignored.
- Push while not full: write mem[wp], wp+1.
- Push while full with no pop: byte dropped, mem/wp unchanged, overflow←1.
- Push while full with simultaneous pop: both are accepted; count stays DEPTH; no overflow.
- Push and pop together while not full or empty: count unchanged.
- Push while empty: rd_valid does not assert until the next cycle, so no same-cycle bypass.
- rd_data/rd_perr = mem[rp], read combinationally from the register array. Valid only while rd_valid; otherwise don't-care.
- overflow: if a set and ovf_clr occur in the same cycle, set wins.
- Timeout counter, width $clog2(TIMEOUT_TICKS+1):
  - Cleared on push, on pop, or while empty.
  - Otherwise increments on each brclk_x2 and saturates at TIMEOUT_TICKS.
  - timeout = (counter==TIMEOUT_TICKS) && !empty.
- Reset, asynchronous, mid-transfer: discards all contents; a partially handled strobe is lost. Memory contents are not reset.

## Timing
- Reset values: rd_valid 0, empty 1, full 0, count 0, thr 0, overflow 0, timeout 0, wp=rp=0.
- Latency: rx_ready at edge N → rd_valid, count, thr, full updated after edge N, i.e. visible in cycle N+1.
- Pop at edge N → next head byte (or rd_valid=0) visible in cycle N+1.
- Sustained throughput: one push plus one pop per cycle.
- All status outputs are registered or derived from registered state only. No combinational path from rx_ready or rd_ready to any output.
- timeout asserts in the cycle after the TIMEOUT_TICKS-th qualifying brclk_x2. It deasserts the cycle after the next push or pop.

## Structure
- Shared package `uart_pkg` holds:
  - UART_DATA_W = 8.
  - Entry width UART_RXQ_W = 9.
  - Default constants RXQ_DEPTH, RXQ_THRESH, RXQ_TIMEOUT_TICKS, shared with the TX-side queue.
- One sub-module, `uart_fifo_mem`: register-array storage with synchronous write port and asynchronous read port, parameterised by width and depth.
- uart_rx_fifo itself holds pointers, count, flags and the timeout counter.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 (perr=0,0,1):
  - rd_valid rises one cycle after the first strobe.
  - Pops return 0x41/0, 0x42/0, 0x43/1.
  - empty is set after the third pop.
- DEPTH=16, push 17 bytes 0x00..0x10 with no reads:
  - full at count 16; overflow=1.
  - Reads return 0x00..0x0F; 0x10 is lost.
  - ovf_clr clears overflow; ovf_clr coincident with a new overflowing push leaves overflow=1.
- Full FIFO, then push 0xAA with rd_ready=1 in the same cycle: no overflow, count stays 16, 0xAA is read last.
- Fill levels 7→8→7 (THRESH=8): thr goes 0→1→0 one cycle after each push/pop. Continuous push+pop every cycle for 100 cycles holds count constant and preserves data order.
- Timeout: push one byte, then no activity.
  - timeout=1 after 80 brclk_x2 ticks.
  - A pop clears it the next cycle, and it stays 0 while empty.
  - With a pending byte, a push at tick 79 restarts the count.
- Async rst asserted mid-stream with 5 bytes queued: all outputs return to reset values immediately, and no stale byte is presented after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-queue entry layout.
// The depth and threshold defaults are also used by the TX-side queue.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_RXQ_W        = 9;
    localparam int RXQ_DEPTH         = 16;
    localparam int RXQ_THRESH        = 8;
    localparam int RXQ_TIMEOUT_TICKS = 80;

    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } rxq_entry_t;

    // Pack a received byte and its parity flag into one queue entry.
    function automatic rxq_entry_t rxq_pack(input logic perr, input logic [UART_DATA_W-1:0] data);
        rxq_entry_t e;
        e.perr = perr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointers alone define what is valid.
module uart_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive queue: first-word-fall-through FIFO with level, threshold,
// sticky overflow and receive-idle timeout status for interrupt generation.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = RXQ_DEPTH,
    parameter int THRESH        = RXQ_THRESH,
    parameter int TIMEOUT_TICKS = RXQ_TIMEOUT_TICKS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     brclk_x2,
    input  logic [UART_DATA_W-1:0]   rx_data,
    input  logic                     rx_perr,
    input  logic                     rx_ready,
    output logic [UART_DATA_W-1:0]   rd_data,
    output logic                     rd_perr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     thr,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          push_s, pop_s, wr_en_s, empty_s, full_s;
    rxq_entry_t    wr_entry_s, rd_entry_s;

    uart_fifo_mem #(
        .WIDTH (UART_RXQ_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wp_q),
        .wdata (wr_entry_s),
        .raddr (rp_q),
        .rdata (rd_entry_s)
    );

    // Handshake decode; a full queue still accepts a byte when the head leaves in the same cycle
    always_comb begin
        empty_s    = (count_q == CW'(0));
        full_s     = (count_q == CW'(DEPTH));
        push_s     = rx_ready;
        pop_s      = !empty_s && rd_ready;
        wr_en_s    = push_s && (!full_s || pop_s);
        wr_entry_s = rxq_pack(rx_perr, rx_data);
    end

    // Next-state for pointers, level and sticky overflow
    always_comb begin
        if (wr_en_s) begin
            wp_d = wp_q + AW'(1);
        end else begin
            wp_d = wp_q;
        end
        if (pop_s) begin
            rp_d = rp_q + AW'(1);
        end else begin
            rp_d = rp_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // a dropped byte takes priority over a coincident clear
        if (push_s && !wr_en_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Idle timeout: restart on any queue activity or while empty, saturate at the limit
    always_comb begin
        if (push_s || pop_s || empty_s) begin
            tmo_d = TW'(0);
        end else if (brclk_x2 && (tmo_q != TW'(TIMEOUT_TICKS))) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= AW'(0);
            rp_q    <= AW'(0);
            count_q <= CW'(0);
            ovf_q   <= 1'b0;
            tmo_q   <= TW'(0);
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outputs depend only on registered state
    always_comb begin
        rd_data  = rd_entry_s.data;
        rd_perr  = rd_entry_s.perr;
        rd_valid = !empty_s;
        count    = count_q;
        empty    = empty_s;
        full     = full_s;
        thr      = (count_q >= CW'(THRESH));
        overflow = ovf_q;
        timeout  = (tmo_q == TW'(TIMEOUT_TICKS)) && !empty_s;
    end

endmodule
